// File: rtl/xadc_drp_responder.sv
// xadc_drp_responder
//   Behavioural stand-in for the XADC hard block: a DRP slave plus a
//   free-running two-channel conversion sequencer (temperature, then VP/VN).
//   Raw 12-bit codes come from input ports and are stored MSB-justified.
//
// Parameters
//   CONV_CYCLES   busy cycles per conversion (4..255)
//   DRDY_LATENCY  cycles from accepted den_in to drdy_out (1..8)
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   den_in, dwe_in      DRP request strobe / write enable
//   daddr_in, di_in     DRP address / write data (sampled with den_in)
//   do_out, drdy_out    DRP read data (zero outside drdy) / completion pulse
//   temp_sample         raw temperature code, captured at temperature eoc
//   vpvn_sample         raw VP/VN code, captured at VP/VN eoc
//   busy_out            conversion in progress
//   channel_out         channel being converted (0x00 temp, 0x03 VP/VN)
//   eoc_out, eos_out    end-of-conversion / end-of-sequence pulses
//   err_out             sticky: request arrived while a transaction was open
//
// Build option
//   XADC_EMU_MINMAX_EN  adds temperature max (0x20) and min (0x24) registers

module xadc_drp_responder #(
  parameter int unsigned CONV_CYCLES  = 26,
  parameter int unsigned DRDY_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        den_in,
  input  logic        dwe_in,
  input  logic [6:0]  daddr_in,
  input  logic [15:0] di_in,
  output logic [15:0] do_out,
  output logic        drdy_out,
  input  logic [11:0] temp_sample,
  input  logic [11:0] vpvn_sample,
  output logic        busy_out,
  output logic [4:0]  channel_out,
  output logic        eoc_out,
  output logic        eos_out,
  output logic        err_out
);

  localparam logic [7:0] CONV_LOAD  = 8'(CONV_CYCLES - 1);
  localparam logic [3:0] DRDY_LOAD  = 4'(DRDY_LATENCY - 1);
  localparam logic [4:0] CH_TEMP    = 5'h00;
  localparam logic [4:0] CH_VPVN    = 5'h03;

  // ---------------------------------------------------------------------------
  // Conversion sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {S_CONV_T, S_CONV_V} seq_state_t;

  seq_state_t  seq_q;
  logic [7:0]  conv_cnt_q;
  logic        busy_q;
  logic        eoc_q;
  logic        eos_q;
  logic [4:0]  chan_q;
  logic [15:0] temp_res_q;
  logic [15:0] vpvn_res_q;
  logic [15:0] temp_new_d;
`ifdef XADC_EMU_MINMAX_EN
  logic [15:0] tmax_q;
  logic [15:0] tmin_q;
`endif

  assign temp_new_d = {temp_sample, 4'h0};

  // The counter is reloaded on the eoc edge and held through the eoc cycle,
  // so busy covers CONV_CYCLES cycles and the period is CONV_CYCLES+1.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= S_CONV_T;
      conv_cnt_q <= CONV_LOAD;
      busy_q     <= 1'b1;
      eoc_q      <= 1'b0;
      eos_q      <= 1'b0;
      chan_q     <= CH_TEMP;
      temp_res_q <= '0;
      vpvn_res_q <= '0;
`ifdef XADC_EMU_MINMAX_EN
      tmax_q     <= '0;
      tmin_q     <= '1;
`endif
    end else if (eoc_q) begin
      eoc_q  <= 1'b0;
      eos_q  <= 1'b0;
      busy_q <= 1'b1;
    end else if (conv_cnt_q == 8'd0) begin
      eoc_q      <= 1'b1;
      busy_q     <= 1'b0;
      conv_cnt_q <= CONV_LOAD;
      case (seq_q)
        S_CONV_T: begin
          temp_res_q <= temp_new_d;
`ifdef XADC_EMU_MINMAX_EN
          if (temp_new_d > tmax_q) tmax_q <= temp_new_d;
          if (temp_new_d < tmin_q) tmin_q <= temp_new_d;
`endif
          eos_q  <= 1'b0;
          seq_q  <= S_CONV_V;
          chan_q <= CH_VPVN;
        end
        default: begin
          vpvn_res_q <= {vpvn_sample, 4'h0};
          eos_q      <= 1'b1;
          seq_q      <= S_CONV_T;
          chan_q     <= CH_TEMP;
        end
      endcase
    end else begin
      conv_cnt_q <= conv_cnt_q - 8'd1;
    end
  end

  assign busy_out    = busy_q;
  assign channel_out = chan_q;
  assign eoc_out     = eoc_q;
  assign eos_out     = eos_q;

  // ---------------------------------------------------------------------------
  // DRP slave
  // ---------------------------------------------------------------------------
  typedef enum logic {D_IDLE, D_WAIT} drp_state_t;

  drp_state_t  drp_q;
  logic [3:0]  dcnt_q;
  logic [6:0]  addr_q;
  logic        we_q;
  logic [15:0] wdata_q;
  logic        drdy_q;
  logic [15:0] do_q;
  logic        err_q;
  logic [15:0] cfg0_q;
  logic [15:0] cfg1_q;
  logic [15:0] cfg2_q;

  logic [6:0]  sel_addr_d;
  logic        sel_we_d;
  logic [15:0] sel_data_d;
  logic        fire_d;
  logic [15:0] rdata_d;

  // With DRDY_LATENCY=1 the transaction completes on the accepting edge, so
  // the request fields are taken straight from the ports while idle.
  always_comb begin
    sel_addr_d = addr_q;
    sel_we_d   = we_q;
    sel_data_d = wdata_q;
    if (drp_q == D_IDLE) begin
      sel_addr_d = daddr_in;
      sel_we_d   = dwe_in;
      sel_data_d = di_in;
    end
  end

  always_comb begin
    fire_d = 1'b0;
    if (drp_q == D_IDLE)
      fire_d = den_in && (DRDY_LATENCY == 1);
    else
      fire_d = !drdy_q && (dcnt_q == 4'd1);
  end

  // Reads see register contents from before the completing edge, so a result
  // updated on that same edge returns its previous value.
  always_comb begin
    rdata_d = '0;
    case (sel_addr_d)
      7'h00:   rdata_d = temp_res_q;
      7'h03:   rdata_d = vpvn_res_q;
      7'h40:   rdata_d = cfg0_q;
      7'h41:   rdata_d = cfg1_q;
      7'h42:   rdata_d = cfg2_q;
`ifdef XADC_EMU_MINMAX_EN
      7'h20:   rdata_d = tmax_q;
      7'h24:   rdata_d = tmin_q;
`endif
      default: rdata_d = '0;
    endcase
  end

  // drdy_q marks the last D_WAIT cycle; a request seen then is still an error.
  always_ff @(posedge clk) begin
    if (rst) begin
      drp_q   <= D_IDLE;
      dcnt_q  <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      drdy_q  <= 1'b0;
      do_q    <= '0;
      err_q   <= 1'b0;
      cfg0_q  <= '0;
      cfg1_q  <= '0;
      cfg2_q  <= '0;
    end else begin
      drdy_q <= fire_d;
      do_q   <= (fire_d && !sel_we_d) ? rdata_d : '0;

      if (fire_d && sel_we_d) begin
        case (sel_addr_d)
          7'h40:   cfg0_q <= sel_data_d;
          7'h41:   cfg1_q <= sel_data_d;
          7'h42:   cfg2_q <= sel_data_d;
          default: ;
        endcase
      end

      case (drp_q)
        D_IDLE: begin
          if (den_in) begin
            drp_q   <= D_WAIT;
            addr_q  <= daddr_in;
            we_q    <= dwe_in;
            wdata_q <= di_in;
            dcnt_q  <= DRDY_LOAD;
          end
        end
        default: begin
          if (den_in) err_q <= 1'b1;
          if (drdy_q)
            drp_q <= D_IDLE;
          else if (dcnt_q != 4'd1)
            dcnt_q <= dcnt_q - 4'd1;
        end
      endcase
    end
  end

  assign do_out   = do_q;
  assign drdy_out = drdy_q;
  assign err_out  = err_q;

endmodule
